ling_modadd_pipe: RTL

- Parametrised, pipelined Ling parallel-prefix adder. Generalises the fixed 8-bit end-around-carry node adder to any width W.
- Two run-time modes:
  - modulo 2^W−1, with end-around carry;
  - ordinary 2^W binary add, with carry-in and carry-out.
- Three register stages, valid/ready handshake on both sides, bubble-collapsing.
- Sits between residue-number datapath stages; builds on the existing gpx / H / P / Lsum cell library.

---
 rtl/ling_modadd_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/ling_modadd_pipe.sv
// rtl/ling_modadd_pipe.sv - 3-stage Ling prefix adder, binary 2^W or modulo 2^W-1 (end-around carry)
// Optional macro LING_MOD_NORMALISE_EN: modulo-mode all-ones result is folded to the single zero.
module ling_modadd_pipe #(
   parameter int           W         = 16,
   parameter logic [W-1:0] RESET_SUM = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         out_mode
);
   localparam int LVL = $clog2(W);

   logic         v1, v2, v3;
   logic         adv1, adv2, adv3;
   logic [W-1:0] g1, p1, x1;
   logic         mode1, cin1;
   logic [W-1:0] h2, p2, x2;
   logic         mode2, cin2;
   logic [W-1:0] h_next, c2, carry_in, sum_next;

   // A stage moves when it is empty or its successor moves, so bubbles collapse.
   assign adv3      = !v3 || out_ready;
   assign adv2      = !v2 || adv3;
   assign adv1      = !v1 || adv2;
   assign in_ready  = adv1;
   assign out_valid = v3;

   // Radix-2 Ling prefix. q[i] holds the propagate chain shifted down by one bit,
   // so level 0 reduces to the classic H1 = g[i] | g[i-1] pair term.
   // Modulo mode rotates (cyclic span); binary mode shifts in the identity element.
   // A cyclic span beyond W only adds terms already implied by the exact-W span.
   function automatic logic [W-1:0] ling_prefix(input logic [W-1:0] g, input logic [W-1:0] p,
                                                input logic mode, input logic cin);
      logic [W-1:0] h, q, hs, qs;
      int           d;
      h = g;
      q = mode ? {p[W-2:0], p[W-1]} : {p[W-2:0], 1'b1};
      for (int l = 0; l < LVL; l++) begin
         d  = 1 << l;
         hs = mode ? ((h << d) | (h >> (W - d))) : (h << d);
         qs = mode ? ((q << d) | (q >> (W - d))) : ((q << d) | ~({W{1'b1}} << d));
         h  = h | (q & hs);
         q  = q & qs;
      end
      return h | (q & {W{~mode & cin}});
   endfunction

   assign h_next   = ling_prefix(g1, p1, mode1, cin1);
   assign c2       = p2 & h2;
   assign carry_in = mode2 ? {c2[W-2:0], c2[W-1]} : {c2[W-2:0], cin2};

   always_comb begin
      sum_next = x2 ^ carry_in;
`ifdef LING_MOD_NORMALISE_EN
      if (mode2 && (&sum_next)) sum_next = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (adv1) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv3) v3 <= v2;
      end
   end

   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         g1    <= in_a & in_b;
         p1    <= in_a | in_b;
         x1    <= in_a ^ in_b;
         mode1 <= in_mode;
         cin1  <= in_cin;
      end
      if (adv2 && v1) begin
         h2    <= h_next;
         p2    <= p1;
         x2    <= x1;
         mode2 <= mode1;
         cin2  <= cin1;
      end
   end

   // Output registers only load real beats, so RESET_SUM persists until the first result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_sum  <= RESET_SUM;
         out_cout <= 1'b0;
         out_mode <= 1'b0;
      end else if (adv3 && v2) begin
         out_sum  <= sum_next;
         out_cout <= c2[W-1];
         out_mode <= mode2;
      end
   end
endmodule
